cover_toggle_collector: RTL and testbench

// - Parametrised successor to the per-bit toggle cover reporters. Samples WIDTH cover strobes per cycle.
// - Records first-hit (sticky) per point and serialises newly hit points as global indices on a valid/ready stream.
// - Sits between instrumented RTL and the coverage sink (DPI bridge or on-chip trace), so it works without DPI.
// - Also keeps a running count of distinct covered points.

---
 rtl/cover_pkg.sv | 23 ++
 rtl/rr_first_set.sv | 42 ++++
 rtl/cover_toggle_collector.sv | 156 +++++++++++++++
 tb/tb_cover_toggle_collector.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared types and constants for the cover toggle collector and its round-robin picker.
package cover_pkg;

    // Default width of an emitted global cover index.
    localparam int IDX_W = 32;

    // Global number of cover points across the whole design.
    localparam int COVER_TOTAL = 10906;

    typedef logic [IDX_W-1:0] cover_idx_t;

    // Output slot: either holds an index waiting for the sink or is free.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Width of a point-number field; at least one bit even for a single point.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_first_set.sv
// Round-robin picker: grants the first set request strictly after i_last,
// wrapping around, so the last granted point is considered last.
module rr_first_set
    import cover_pkg::*;
#(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0]        i_req,
    input  logic [idx_w(WIDTH)-1:0] i_last,
    output logic [WIDTH-1:0]        o_gnt_onehot,
    output logic [idx_w(WIDTH)-1:0] o_gnt_idx
);

    localparam int LAST_W = idx_w(WIDTH);

    logic [LAST_W:0]   w_pos;
    logic [LAST_W-1:0] w_sel;
    logic              w_found;

    // Scan WIDTH positions starting just after i_last and take the first request.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        w_found      = 1'b0;
        w_pos        = '0;
        w_sel        = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            w_pos = {1'b0, i_last} + (LAST_W + 1)'(k);
            if (w_pos >= (LAST_W + 1)'(WIDTH)) begin
                w_pos = w_pos - (LAST_W + 1)'(WIDTH);
            end
            w_sel = w_pos[LAST_W-1:0];
            if (!w_found && i_req[w_sel]) begin
                w_found             = 1'b1;
                o_gnt_onehot[w_sel] = 1'b1;
                o_gnt_idx           = w_sel;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Cover toggle collector: records first hits per point, counts distinct covered
// points and serialises hit points as global indices on a valid/ready stream.
module cover_toggle_collector #(
    parameter int WIDTH       = 40,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
    parameter int IDX_W       = cover_pkg::IDX_W,
    parameter int DEDUP       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic [$clog2(WIDTH+1)-1:0] covered_cnt,
    output logic                       all_covered,
    output logic                       dropped
);
    import cover_pkg::*;

    localparam int LAST_W = idx_w(WIDTH);
    localparam int CNT_W  = $clog2(WIDTH + 1);

    // An instance whose points fall outside the global index space is a build error.
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $fatal(1, "cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0]  r_seen;
    logic [WIDTH-1:0]  r_pending;
    logic [LAST_W-1:0] r_last_grant;
    slot_state_e       r_state;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_index;
    logic [CNT_W-1:0]  r_covered_cnt;
    logic              r_all_covered;
    logic              r_dropped;

    logic [WIDTH-1:0]  w_hit;
    logic [WIDTH-1:0]  w_new;
    logic [WIDTH-1:0]  w_set;
    logic [WIDTH-1:0]  w_gnt_onehot;
    logic [WIDTH-1:0]  w_drain;
    logic [LAST_W-1:0] w_gnt_idx;
    logic              w_accept;
    logic              w_load;
    logic              w_drop_hit;
    logic [CNT_W-1:0]  w_popcnt;
    logic [CNT_W:0]    w_cnt_sum;
    logic [CNT_W-1:0]  w_cnt_next;

    // clear outranks sampling: strobes in the clear cycle are discarded.
    assign w_hit = (en && !clear) ? valid : '0;
    assign w_new = w_hit & ~r_seen;
    assign w_set = (DEDUP != 0) ? w_new : w_hit;

    // A load happens when the slot is free, or is being emptied this cycle, and work is pending.
    assign w_accept = r_out_valid & out_ready;
    assign w_load   = !clear && (|r_pending) && ((r_state == SLOT_EMPTY) || w_accept);
    assign w_drain  = w_load ? w_gnt_onehot : '0;

    // A repeat hit on a point that is still pending (and not leaving now) is merged and lost.
    assign w_drop_hit = (DEDUP == 0) && (|(w_hit & r_pending & ~w_drain));

    rr_first_set #(
        .WIDTH (WIDTH)
    ) u_rr_first_set (
        .i_req        (r_pending),
        .i_last       (r_last_grant),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx)
    );

    // Count newly covered points this cycle and saturate the running total at WIDTH.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + CNT_W'(w_new[i]);
        end
        w_cnt_sum  = {1'b0, r_covered_cnt} + {1'b0, w_popcnt};
        w_cnt_next = (w_cnt_sum > (CNT_W + 1)'(WIDTH)) ? CNT_W'(WIDTH) : w_cnt_sum[CNT_W-1:0];
    end

    // Sticky seen/pending bookkeeping, coverage count and drop flag.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_seen        <= '0;
            r_pending     <= '0;
            r_covered_cnt <= '0;
            r_all_covered <= 1'b0;
            r_dropped     <= 1'b0;
        end else if (clear) begin
            r_seen        <= '0;
            r_pending     <= '0;
            r_covered_cnt <= '0;
            r_all_covered <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            r_seen        <= r_seen | w_hit;
            // The drained bit is cleared first so a same-cycle hit re-arms it.
            r_pending     <= (r_pending & ~w_drain) | w_set;
            r_covered_cnt <= w_cnt_next;
            r_all_covered <= (w_cnt_next == CNT_W'(WIDTH));
            if (w_drop_hit) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // Output slot FSM: load from the picker, hold until accepted, reload back-to-back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= SLOT_EMPTY;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_last_grant <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_load) begin
                        r_state      <= SLOT_FULL;
                        r_out_valid  <= 1'b1;
                        r_out_index  <= IDX_W'(COVER_INDEX) + IDX_W'(w_gnt_idx);
                        r_last_grant <= w_gnt_idx;
                    end
                end
                SLOT_FULL: begin
                    if (w_accept) begin
                        if (w_load) begin
                            r_out_index  <= IDX_W'(COVER_INDEX) + IDX_W'(w_gnt_idx);
                            r_last_grant <= w_gnt_idx;
                        end else begin
                            r_state     <= SLOT_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= SLOT_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_index   = r_out_index;
    assign covered_cnt = r_covered_cnt;
    assign all_covered = r_all_covered;
    assign dropped     = r_dropped;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: a DEDUP=1 and a DEDUP=0 instance share
// stimulus and are compared every cycle against a point-level reference model,
// plus directed checks on the emitted index sequences.
module tb_cover_toggle_collector;
    import cover_pkg::*;

    localparam int NPTS = 40;
    localparam int CI0  = 0;
    localparam int CI1  = 1000;

    logic             clock;
    logic             reset;
    logic             en;
    logic [NPTS-1:0]  valid;
    logic             clear;
    logic             out_ready;
    logic             ov0, ov1;
    cover_idx_t       oi0, oi1;
    logic [5:0]       cc0, cc1;
    logic             ac0, ac1;
    logic             dr0, dr1;

    int n_tests;
    int n_fail;

    int q0[$];
    int q1[$];

    // Reference model, one set per instance: [0] DEDUP=1, [1] DEDUP=0.
    bit m_seen [2][NPTS];
    bit m_pend [2][NPTS];
    int m_last [2];
    bit m_full [2];
    int m_idx  [2];
    int m_cnt  [2];
    bit m_drop [2];

    cover_toggle_collector #(
        .WIDTH (NPTS), .COVER_INDEX (CI0), .DEDUP (1)
    ) u_dut_dedup (
        .clock (clock), .reset (reset), .en (en), .valid (valid), .clear (clear),
        .out_valid (ov0), .out_ready (out_ready), .out_index (oi0),
        .covered_cnt (cc0), .all_covered (ac0), .dropped (dr0)
    );

    cover_toggle_collector #(
        .WIDTH (NPTS), .COVER_INDEX (CI1), .DEDUP (0)
    ) u_dut_all (
        .clock (clock), .reset (reset), .en (en), .valid (valid), .clear (clear),
        .out_valid (ov1), .out_ready (out_ready), .out_index (oi1),
        .covered_cnt (cc1), .all_covered (ac1), .dropped (dr1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NPTS; i++) begin
                m_seen[d][i] = 1'b0;
                m_pend[d][i] = 1'b0;
            end
            m_last[d] = 0;
            m_full[d] = 1'b0;
            m_idx[d]  = 0;
            m_cnt[d]  = 0;
            m_drop[d] = 1'b0;
        end
    endfunction

    // One clock edge of the behavioural rules, using the inputs held during the cycle.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            bit dedup_mode;
            bit any_pend;
            bit accept;
            int drained;
            dedup_mode = (d == 0);
            any_pend   = 1'b0;
            accept     = m_full[d] && out_ready;
            drained    = -1;
            for (int i = 0; i < NPTS; i++) any_pend |= m_pend[d][i];
            if (!clear && any_pend && (!m_full[d] || accept)) begin
                for (int k = 1; k <= NPTS; k++) begin
                    int p;
                    p = (m_last[d] + k) % NPTS;
                    if (drained < 0 && m_pend[d][p]) drained = p;
                end
                m_idx[d]  = drained;
                m_last[d] = drained;
                m_full[d] = 1'b1;
                m_pend[d][drained] = 1'b0;
            end else if (accept) begin
                m_full[d] = 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < NPTS; i++) begin
                    m_seen[d][i] = 1'b0;
                    m_pend[d][i] = 1'b0;
                end
                m_cnt[d]  = 0;
                m_drop[d] = 1'b0;
            end else if (en) begin
                for (int i = 0; i < NPTS; i++) begin
                    if (valid[i]) begin
                        if (!dedup_mode && m_pend[d][i]) m_drop[d] = 1'b1;
                        if (!m_seen[d][i]) begin
                            m_seen[d][i] = 1'b1;
                            m_pend[d][i] = 1'b1;
                            if (m_cnt[d] < NPTS) m_cnt[d]++;
                        end else if (!dedup_mode) begin
                            m_pend[d][i] = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("d0 out_valid", longint'(ov0), longint'(m_full[0]));
        check("d1 out_valid", longint'(ov1), longint'(m_full[1]));
        if (m_full[0]) check("d0 out_index", longint'(oi0), longint'(CI0 + m_idx[0]));
        if (m_full[1]) check("d1 out_index", longint'(oi1), longint'(CI1 + m_idx[1]));
        check("d0 covered_cnt", longint'(cc0), longint'(m_cnt[0]));
        check("d1 covered_cnt", longint'(cc1), longint'(m_cnt[1]));
        check("d0 all_covered", longint'(ac0), longint'(m_cnt[0] == NPTS));
        check("d1 all_covered", longint'(ac1), longint'(m_cnt[1] == NPTS));
        check("d0 dropped", longint'(dr0), longint'(m_drop[0]));
        check("d1 dropped", longint'(dr1), longint'(m_drop[1]));
    endtask

    // Log accepted transfers, advance one clock, update the model, compare at the falling edge.
    task automatic cycle();
        if (ov0 === 1'b1 && out_ready === 1'b1) q0.push_back(int'(oi0));
        if (ov1 === 1'b1 && out_ready === 1'b1) q1.push_back(int'(oi1));
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int k);
        if (k < q.size()) return q[k];
        return -1;
    endfunction

    logic [63:0] rnd;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        en        = 1'b1;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) cycle();
        check("rst out_valid", longint'(ov0), 0);
        check("rst out_index", longint'(oi0), 0);
        check("rst covered_cnt", longint'(cc1), 0);
        reset = 1'b1;

        // Single hit on point 0: one transfer two cycles later.
        out_ready = 1'b1;
        valid = 40'h1;
        cycle();
        valid = '0;
        cycle();
        check("s1 valid at t+2", longint'(ov0), 1);
        repeat (4) cycle();
        check("s1 d0 count", longint'(q0.size()), 1);
        check("s1 d0 index", longint'(q_at(q0, 0)), CI0);
        check("s1 d1 index", longint'(q_at(q1, 0)), CI1);
        check("s1 covered", longint'(cc0), 1);

        // Leave last_grant at 39 so the next burst starts from point 0.
        do_clear();
        valid = 40'h80_0000_0000;
        cycle();
        valid = '0;
        repeat (4) cycle();
        do_clear();
        q0.delete();
        q1.delete();

        // Burst of all 40 points with 10 stalled cycles.
        out_ready = 1'b0;
        valid = 40'hFF_FFFF_FFFF;
        cycle();
        valid = '0;
        cycle();
        repeat (10) begin
            cycle();
            check("s2 stall valid", longint'(ov0), 1);
            check("s2 stall index", longint'(oi0), CI0);
        end
        out_ready = 1'b1;
        repeat (45) cycle();
        check("s2 d0 count", longint'(q0.size()), 40);
        check("s2 d1 count", longint'(q1.size()), 40);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("s2 d0 seq %0d", k), longint'(q_at(q0, k)), longint'(CI0 + k));
            check($sformatf("s2 d1 seq %0d", k), longint'(q_at(q1, k)), longint'(CI1 + k));
        end
        check("s2 all_covered", longint'(ac0), 1);

        // Repeated hits on point 5, four cycles apart.
        do_clear();
        q0.delete();
        q1.delete();
        repeat (3) begin
            valid = 40'd1 << 5;
            cycle();
            valid = '0;
            repeat (3) cycle();
        end
        repeat (4) cycle();
        check("s3 d0 count", longint'(q0.size()), 1);
        check("s3 d0 index", longint'(q_at(q0, 0)), CI0 + 5);
        check("s3 d1 count", longint'(q1.size()), 3);
        check("s3 covered", longint'(cc0), 1);

        // Coalescing: slot blocked by point 7, point 3 hit twice while pending.
        do_clear();
        q0.delete();
        q1.delete();
        out_ready = 1'b0;
        valid = 40'd1 << 7;
        cycle();
        valid = '0;
        repeat (2) cycle();
        valid = 40'd1 << 3;
        cycle();
        valid = '0;
        cycle();
        valid = 40'd1 << 3;
        cycle();
        valid = '0;
        cycle();
        check("s4 d1 dropped", longint'(dr1), 1);
        check("s4 d0 dropped", longint'(dr0), 0);
        out_ready = 1'b1;
        repeat (5) cycle();
        check("s4 d1 count", longint'(q1.size()), 2);
        check("s4 d1 first", longint'(q_at(q1, 0)), CI1 + 7);
        check("s4 d1 second", longint'(q_at(q1, 1)), CI1 + 3);
        valid = 40'd1 << 3;
        cycle();
        valid = '0;
        repeat (5) cycle();
        check("s4 d1 re-emit count", longint'(q1.size()), 3);
        check("s4 d1 re-emit index", longint'(q_at(q1, 2)), CI1 + 3);
        check("s4 d0 count", longint'(q0.size()), 2);

        // Round robin: points 0 and 1 held high.
        do_clear();
        q0.delete();
        q1.delete();
        valid = 40'h3;
        repeat (14) cycle();
        valid = '0;
        repeat (4) cycle();
        check("s5 d1 min count", longint'(q1.size() >= 10), 1);
        check("s5 d1 first", longint'(q_at(q1, 0) == CI1 || q_at(q1, 0) == CI1 + 1), 1);
        for (int k = 1; k < q1.size(); k++) begin
            check($sformatf("s5 d1 alt %0d", k), longint'(q1[k]),
                  longint'((q1[k-1] == CI1) ? CI1 + 1 : CI1));
        end
        check("s5 d0 count", longint'(q0.size()), 2);

        // clear while FULL with more points pending.
        do_clear();
        out_ready = 1'b0;
        valid = 40'hFF;
        cycle();
        valid = '0;
        repeat (2) cycle();
        q0.delete();
        q1.delete();
        do_clear();
        out_ready = 1'b1;
        repeat (8) cycle();
        check("s6 d0 count", longint'(q0.size()), 1);
        check("s6 d1 count", longint'(q1.size()), 1);
        check("s6 covered", longint'(cc0), 0);

        // Randomised traffic against the model.
        repeat (600) begin
            en        = ($urandom_range(3) != 0);
            rnd       = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            valid     = rnd[NPTS-1:0];
            clear     = ($urandom_range(63) == 0);
            out_ready = ($urandom_range(1) == 1);
            cycle();
        end
        en    = 1'b1;
        valid = '0;
        clear = 1'b0;

        // Reset in the middle of a burst.
        do_clear();
        out_ready = 1'b1;
        valid = 40'hFF_FFFF_FFFF;
        cycle();
        valid = '0;
        repeat (4) cycle();
        check("s8 streaming", longint'(ov0), 1);
        #2 reset = 1'b0;
        #1;
        check("s8 async out_valid d0", longint'(ov0), 0);
        check("s8 async out_valid d1", longint'(ov1), 0);
        check("s8 async covered", longint'(cc0), 0);
        check("s8 async all_covered", longint'(ac1), 0);
        check("s8 async dropped", longint'(dr1), 0);
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        repeat (5) cycle();
        check("s8 nothing after reset d0", longint'(q0.size()), 0);
        check("s8 nothing after reset d1", longint'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
